// File: rtl/icache_pkg.sv
// Shared state encoding and geometry helpers for the icache refill responder.
package icache_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_GAP,
    S_DONE,
    S_HOLD
  } refill_state_t;

  // Number of byte-address bits covered by one refill block.
  function automatic int block_offset_bits(input int words_per_block);
    return $clog2(words_per_block * WORD_BYTES);
  endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Word-wide backing store: one synchronous write port, one combinational read port.
module imem_word_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset; its contents are loaded through the write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A register sampling rdata on the same edge as a write sees the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_refill_responder.sv
// Memory-side responder that returns one icache block per miss, word by word.
module imem_refill_responder
  import icache_pkg::*;
#(
  parameter int WORDSPERBLOCK = 4,
  parameter int MEMWORDS      = 1024,
  parameter int LATENCY       = 2,
  parameter int GAP           = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miss,
  input  logic [31:0] fetchaddr,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] ifetch,
  output logic        iready,
  output logic        busy,
  output logic        done
);

  localparam int AW   = $clog2(MEMWORDS);
  localparam int BW   = $clog2(WORDSPERBLOCK);
  localparam int OFFW = block_offset_bits(WORDSPERBLOCK);
  // Counters are loaded one short because the transition edge is itself a cycle.
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  refill_state_t   state;
  logic [3:0]      cnt;
  logic [BW-1:0]   beat;
  logic [AW-1:0]   base_word;
  logic [AW-1:0]   req_base;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_data;
  logic            last_beat;
  logic            unused_addr_bits;

  assign req_base  = {fetchaddr[AW+1:OFFW], {BW{1'b0}}};
  assign last_beat = (beat == BW'(WORDSPERBLOCK - 1));
  assign unused_addr_bits = ^{fetchaddr[31:AW+2], fetchaddr[OFFW-1:0],
                              wr_addr[31:AW+2], wr_addr[1:0]};

  // Address of the word the next beat will return, presented one cycle ahead.
  // NOTE: rd_idx gets a default before the case so no latch is inferred.
  always_comb begin
    rd_idx = base_word + AW'(beat);
    case (state)
      S_IDLE:  rd_idx = req_base;
      S_BEAT:  rd_idx = base_word + AW'(beat) + AW'(1);
      default: ;
    endcase
  end

  imem_word_ram #(.DEPTH(MEMWORDS)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr[AW+1:2]),
    .wdata (wr_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // NOTE: every register here uses <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      beat      <= '0;
      base_word <= '0;
      ifetch    <= '0;
      iready    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      iready <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss) begin
            base_word <= req_base;
            beat      <= '0;
            busy      <= 1'b1;
            if (LATENCY == 0) begin
              state  <= S_BEAT;
              iready <= 1'b1;
              ifetch <= rd_data;
            end else begin
              state <= S_WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        S_WAIT, S_GAP: begin
          if (cnt == 4'd0) begin
            state  <= S_BEAT;
            iready <= 1'b1;
            ifetch <= rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_BEAT: begin
          if (last_beat) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            beat <= beat + BW'(1);
            if (GAP == 0) begin
              iready <= 1'b1;
              ifetch <= rd_data;
            end else begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end
          end
        end
        S_DONE: begin
          if (miss) begin
            state <= S_HOLD;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!miss) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_refill_responder.sv
// Bench for imem_refill_responder: two instances (slow and zero-wait timing) share one stimulus.
module tb_imem_refill_responder;

  localparam int WPB   = 4;
  localparam int LAT_A = 2;
  localparam int GAP_A = 1;
  localparam int LAT_B = 0;
  localparam int GAP_B = 0;

  typedef struct {
    logic        sel;    // 0: slow instance, 1: zero-wait instance
    logic [31:0] addr;
    logic [31:0] first;  // word expected on beat 0; beat k returns first + k
  } vec_t;

  logic        clk, reset, miss_a, miss_b, wr_en;
  logic [31:0] fetchaddr, wr_addr, wr_data;
  logic [31:0] ifetch_a, ifetch_b;
  logic        iready_a, iready_b, busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;
  int beats_a  = 0;
  int beats_b  = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  vec_t vecs[6];

  imem_refill_responder #(.WORDSPERBLOCK(WPB), .MEMWORDS(1024), .LATENCY(LAT_A), .GAP(GAP_A)) dut_a (
    .clk(clk), .reset(reset), .miss(miss_a), .fetchaddr(fetchaddr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ifetch(ifetch_a), .iready(iready_a), .busy(busy_a), .done(done_a)
  );

  imem_refill_responder #(.WORDSPERBLOCK(WPB), .MEMWORDS(1024), .LATENCY(LAT_B), .GAP(GAP_B)) dut_b (
    .clk(clk), .reset(reset), .miss(miss_b), .fetchaddr(fetchaddr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ifetch(ifetch_b), .iready(iready_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check1(input string name, input logic actual, input logic expected);
    check(name, {31'd0, actual}, {31'd0, expected});
  endtask

  // Scoreboard: every iready beat must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (iready_a) begin
      beats_a++;
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL beat_a: got unexpected beat %h, expected no beat", ifetch_a);
      end else check("beat_a_data", ifetch_a, q_a.pop_front());
    end
    if (iready_b) begin
      beats_b++;
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL beat_b: got unexpected beat %h, expected no beat", ifetch_b);
      end else check("beat_b_data", ifetch_b, q_b.pop_front());
    end
  end

  task automatic push_word(input logic sel, input logic [31:0] w);
    if (sel) q_b.push_back(w); else q_a.push_back(w);
  endtask

  task automatic push_block(input logic sel, input logic [31:0] first);
    for (int k = 0; k < WPB; k++) push_word(sel, first + 32'(k));
  endtask

  // Called just after a rising edge; returns just after the acceptance edge (cycle 1).
  task automatic request(input logic sel, input logic [31:0] addr);
    fetchaddr = addr;
    if (sel) miss_b = 1'b1; else miss_a = 1'b1;
    @(posedge clk); #1;
    miss_a = 1'b0;
    miss_b = 1'b0;
    fetchaddr = ~addr;  // must be ignored while busy
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input logic sel, input int budget, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check1(name, seen, 1'b1);
  endtask

  function automatic logic beat_cycle(input int c, input int lat, input int gp);
    int rel = c - 1 - lat;
    return (rel >= 0) && (rel % (gp + 1) == 0) && (rel / (gp + 1) < WPB);
  endfunction

  task automatic run_refill(input int idx, input vec_t v);
    int lat = v.sel ? LAT_B : LAT_A;
    int gp  = v.sel ? GAP_B : GAP_A;
    int d   = 2 + lat + (WPB - 1) * (gp + 1);
    push_block(v.sel, v.first);
    request(v.sel, v.addr);
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      check1($sformatf("v%0d_iready_c%0d", idx, c), v.sel ? iready_b : iready_a, beat_cycle(c, lat, gp));
      check1($sformatf("v%0d_done_c%0d", idx, c), v.sel ? done_b : done_a, c == d);
      check1($sformatf("v%0d_busy_c%0d", idx, c), v.sel ? busy_b : busy_a, c <= d);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    vecs[0] = '{sel: 1'b0, addr: 32'h0000_0014, first: 32'hC0DE_0004};
    vecs[1] = '{sel: 1'b0, addr: 32'h0000_0100, first: 32'hC0DE_0040};
    vecs[2] = '{sel: 1'b1, addr: 32'h0000_0000, first: 32'hC0DE_0000};
    vecs[3] = '{sel: 1'b0, addr: 32'h0000_1000, first: 32'hC0DE_0000};
    vecs[4] = '{sel: 1'b1, addr: 32'h0000_3FFC, first: 32'hC0DE_03FC};
    vecs[5] = '{sel: 1'b0, addr: 32'h0000_002B, first: 32'hC0DE_0008};

    reset = 1'b0; miss_a = 1'b0; miss_b = 1'b0; wr_en = 1'b0;
    fetchaddr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ifetch_a", ifetch_a, 32'h0);
    check1("rst_iready_a", iready_a, 1'b0);
    check1("rst_busy_a", busy_a, 1'b0);
    check1("rst_done_a", done_a, 1'b0);
    check("rst_ifetch_b", ifetch_b, 32'h0);
    check1("rst_busy_b", busy_b, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 1024; i++) write_word(32'(i * 4), {16'hC0DE, 16'(i)});

    for (int i = 0; i < 6; i++) run_refill(i, vecs[i]);

    // Write during beat 0 to a later word of the same block: beat 2 sees it.
    push_word(0, 32'hC0DE_0004); push_word(0, 32'hC0DE_0005);
    push_word(0, 32'hDEAD_BEEF); push_word(0, 32'hC0DE_0007);
    request(0, 32'h10);
    repeat (2) begin @(posedge clk); #1; end
    check1("coll1_beat0_now", iready_a, 1'b1);
    write_word(32'h18, 32'hDEAD_BEEF);
    wait_done(0, 20, "coll1_done");

    // Write during beat 0 to beat 0's own word: that beat returns the old value.
    push_word(0, 32'hC0DE_0004); push_word(0, 32'hC0DE_0005);
    push_word(0, 32'hDEAD_BEEF); push_word(0, 32'hC0DE_0007);
    request(0, 32'h10);
    repeat (2) begin @(posedge clk); #1; end
    check1("coll2_beat0_now", iready_a, 1'b1);
    write_word(32'h10, 32'h1234_5678);
    wait_done(0, 20, "coll2_done");

    push_word(0, 32'h1234_5678); push_word(0, 32'hC0DE_0005);
    push_word(0, 32'hDEAD_BEEF); push_word(0, 32'hC0DE_0007);
    request(0, 32'h10);
    wait_done(0, 20, "coll3_done");
    write_word(32'h10, 32'hC0DE_0004);
    write_word(32'h18, 32'hC0DE_0006);

    // Miss held high across the block end: HOLD, no duplicate refill.
    b0 = beats_a;
    push_block(0, 32'hC0DE_0004);
    fetchaddr = 32'h14; miss_a = 1'b1;
    wait_done(0, 30, "b2b_first_done");
    check("b2b_first_beats", 32'(beats_a - b0), 32'd4);
    repeat (6) begin
      @(negedge clk);
      check1("b2b_hold_busy", busy_a, 1'b1);
      @(posedge clk); #1;
    end
    check("b2b_no_dup", 32'(beats_a - b0), 32'd4);
    miss_a = 1'b0;
    @(posedge clk); #1;
    check1("b2b_idle", busy_a, 1'b0);
    push_block(0, 32'hC0DE_0040);
    request(0, 32'h100);
    wait_done(0, 30, "b2b_second_done");
    check("b2b_second_beats", 32'(beats_a - b0), 32'd8);

    // Reset between beats 1 and 2: outputs drop at once, no done, then a fresh block.
    b0 = beats_a;
    push_block(0, 32'hC0DE_0004);
    request(0, 32'h14);
    repeat (5) begin @(posedge clk); #1; end
    check("rst_mid_beats", 32'(beats_a - b0), 32'd2);
    check1("rst_mid_busy_before", busy_a, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check1("rst_mid_busy", busy_a, 1'b0);
    check1("rst_mid_iready", iready_a, 1'b0);
    check1("rst_mid_done", done_a, 1'b0);
    q_a.delete();
    repeat (3) begin
      @(negedge clk);
      check1("rst_hold_iready", iready_a, 1'b0);
      check1("rst_hold_done", done_a, 1'b0);
    end
    check("rst_mid_no_more_beats", 32'(beats_a - b0), 32'd2);
    fetchaddr = 32'h20; miss_a = 1'b1;
    push_block(0, 32'hC0DE_0008);
    reset = 1'b1;
    @(posedge clk); #1;
    miss_a = 1'b0;
    wait_done(0, 20, "rst_fresh_done");
    check("rst_fresh_beats", 32'(beats_a - b0), 32'd6);

    repeat (3) @(posedge clk);
    check("sb_a_empty", 32'(q_a.size()), 32'd0);
    check("sb_b_empty", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_refill_responder.md
Name: imem_refill_responder

Overview:
- Memory-side responder for the direct-mapped icache refill interface.
- Watches the cache's miss/fetchaddr request and returns one cache block of WORDSPERBLOCK words. Each word is driven on ifetch and marked by a single-cycle iready pulse, after a programmable access latency.
- Holds a word-addressed backing store, preloaded through a write port; it serves as the instruction memory in cache-level benches and in the SoC model.

Parameters:
- WORDSPERBLOCK, 4, words per refill block; power of two, ≥2.
- MEMWORDS, 1024, depth of the backing store in 32-bit words; power of two.
- LATENCY, 2, idle cycles between request acceptance and the first beat; 0..15.
- GAP, 1, idle cycles between consecutive beats; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- miss  in  1  refill request from the cache, level.
- fetchaddr  in  32  byte address of the missing instruction.
- wr_en  in  1  backing-store write strobe.
- wr_addr  in  32  byte address for the write; bits [1:0] are ignored.
- wr_data  in  32  write data.
- ifetch  out  32  refill data word.
- iready  out  1  one-cycle strobe: ifetch is valid this cycle.
- busy  out  1  high while a refill is in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last beat of a block.

Behaviour:
- All outputs are registered.
- Reset values: ifetch=0, iready=0, busy=0, done=0, state=IDLE, counters=0. Backing-store contents are not reset.
- States and transitions:
  - IDLE: on a clock edge with miss=1, capture base = fetchaddr with bits [log2(WORDSPERBLOCK*4)-1:0] cleared. Set beat=0 and go to WAIT, loading the wait counter with LATENCY.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to BEAT (LATENCY=0 means BEAT is the cycle after acceptance).
  - BEAT: iready=1 for exactly one cycle; ifetch = mem[(base>>2 + beat) mod MEMWORDS]. If beat < WORDSPERBLOCK-1, increment beat and go to GAP (load GAP), or straight to the next BEAT when GAP=0. Otherwise go to DONE.
  - GAP: iready=0 and ifetch holds its last value. Count down, then go to BEAT.
  - DONE: done=1 for one cycle. Go to IDLE if miss=0, else go to HOLD.
  - HOLD: stay until miss=0, then go to IDLE. A miss held high across a block end therefore never triggers a duplicate refill.
- Timing: with acceptance at edge 0, beat k's iready is high in cycle 1+LATENCY+k*(GAP+1), and done is high the cycle after the last beat.
- Beat order: words are returned in ascending address order from base; there is no critical-word-first. Index arithmetic is modulo MEMWORDS, so an address beyond the store wraps.
- Requests during a refill: changes to miss or fetchaddr while busy are ignored; the captured base is used.
- Backing-store writes: a write is accepted in any state and lands at the clock edge. If wr_addr matches a word whose beat occurs in the same cycle, the beat returns the old data (read-before-write). Later beats see the new data.
- Reset mid-refill: iready, done and busy drop to 0 immediately (asynchronously), with no partial-block completion. After reset release, the FSM starts in IDLE and a still-high miss is accepted as a new request.

Decomposition:
- Shared package icache_pkg holds:
  - the state enum (IDLE, WAIT, BEAT, GAP, DONE, HOLD);
  - WORD_BYTES=4;
  - a function computing the block-offset width from WORDSPERBLOCK.
- One sub-module, imem_word_ram: MEMWORDS x 32, one synchronous write port and one read port, read-before-write.
- The FSM and counters stay in the top module.

Test Plan:
- Basic refill: preload mem[i]={16'hC0DE,i[15:0]}; LATENCY=2, GAP=1; miss=1 with fetchaddr=0x14 at edge 0 -> iready high in cycles 3,5,7,9 with ifetch 0xC0DE0004..0xC0DE0007, done in cycle 10, busy high in cycles 1..10.
- Back-to-back: miss held high through DONE -> FSM enters HOLD with no second refill. Drop miss for 1 cycle, then raise it with fetchaddr=0x100 -> a new block returns 0xC0DE0040..0xC0DE0043.
- Timing corner: LATENCY=0, GAP=0, fetchaddr=0x0 -> iready high in cycles 1..4 contiguously; done in cycle 5.
- Wrap: fetchaddr=0x00001000 with MEMWORDS=1024 -> words 0..3 are returned (0xC0DE0000..3).
- Write collision: during the refill of base 0x10, write 0xDEADBEEF to 0x18 in beat-0's cycle -> beat 2 returns 0xDEADBEEF. A write to 0x10 in beat-0's cycle -> beat 0 returns the old 0xC0DE0004.
- Reset mid-refill: assert reset between beats 1 and 2 -> iready=0 and busy=0 immediately, with no done pulse. Release with miss=1 and fetchaddr=0x20 -> a fresh full block 0xC0DE0008..0xC0DE000B.
